pov_spi_tx: RTL and testbench

Serialises one set of point-of-view vectors (playerX/Y, facingX/Y, vplaneX/Y) into an SPI frame that the vector SPI port of the renderer (`i_sclk`/`i_mosi`/`i_ss_n`) accepts. It is the transmitting end of that link. It sits in FPGA/demo top levels and in testbenches, between a vector source (controller logic or soft CPU) and the renderer. The renderer applies a received frame at its next visible-frame end.

---
 rtl/pov_spi_tx.sv | 187 ++++++++++++++++++
 tb/tb_pov_spi_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pov_spi_tx.sv
// pov_spi_tx
// ----------
// Transmitting end of the renderer's vector SPI link. One request captures the
// six point-of-view vectors into a shift register and sends them as a single
// SPI mode-0 frame, MSB first, in the order playerX, playerY, facingX, facingY,
// vplaneX, vplaneY. The frame is followed by a short trailer with SS still low
// and then an inter-frame gap with SS high. New requests are accepted only
// once that gap is over.
//
// Optional build macro:
//   POV_TX_AUTO_EN : a registered rising edge on i_vsync also starts a frame.
//                    Without it i_vsync is ignored.
//
// Ports:
//   clk                    system clock, the only clock
//   reset_n                asynchronous, active-low reset
//   i_start                start request, sampled only while idle
//   i_playerX/Y            player position (POS_BITS each)
//   i_facingX/Y            facing direction (DIR_BITS each)
//   i_vplaneX/Y            view plane (DIR_BITS each)
//   i_vsync                renderer vsync (used only with POV_TX_AUTO_EN)
//   o_sclk                 SPI clock, idles low
//   o_mosi                 serial data
//   o_ss_n                 active-low frame select
//   o_busy                 high from accept until the end of the gap
//   o_done                 one-cycle pulse at frame completion
module pov_spi_tx #(
   parameter int POS_BITS = 15,
   parameter int DIR_BITS = 11,
   parameter int CLK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_start,
   input  logic [POS_BITS-1:0] i_playerX,
   input  logic [POS_BITS-1:0] i_playerY,
   input  logic [DIR_BITS-1:0] i_facingX,
   input  logic [DIR_BITS-1:0] i_facingY,
   input  logic [DIR_BITS-1:0] i_vplaneX,
   input  logic [DIR_BITS-1:0] i_vplaneY,
   input  logic                i_vsync,
   output logic                o_sclk,
   output logic                o_mosi,
   output logic                o_ss_n,
   output logic                o_busy,
   output logic                o_done
);

   localparam int N    = 2 * POS_BITS + 4 * DIR_BITS;
   localparam int BC_W = $clog2(N);
   // A divider of 1 would give a zero-width phase counter; keep one bit.
   localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_TRAIL,
      S_GAP
   } state_t;

   state_t          state_reg;
   logic [N-1:0]    shift_reg;
   logic [BC_W-1:0] bit_cnt_reg;
   logic [PH_W-1:0] phase_reg;
   logic            sclk_reg;
   logic            mosi_reg;
   logic            ss_n_reg;
   logic            busy_reg;
   logic            done_reg;

   logic [N-1:0]    frame_w;
   logic            req_w;

   assign frame_w = {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};

`ifdef POV_TX_AUTO_EN
   logic vsync_q_reg;
   logic vsync_edge_reg;

   // Edge pulse is registered, so it reaches the FSM one cycle after the rise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q_reg    <= 1'b0;
         vsync_edge_reg <= 1'b0;
      end else begin
         vsync_q_reg    <= i_vsync;
         vsync_edge_reg <= i_vsync & ~vsync_q_reg;
      end
   end

   assign req_w = i_start | vsync_edge_reg;
`else
   logic unused_vsync;

   assign unused_vsync = i_vsync;
   assign req_w        = i_start;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         phase_reg   <= '0;
         sclk_reg    <= 1'b0;
         mosi_reg    <= 1'b0;
         ss_n_reg    <= 1'b1;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (req_w) begin
                  state_reg   <= S_SHIFT;
                  shift_reg   <= frame_w;
                  mosi_reg    <= frame_w[N-1];
                  ss_n_reg    <= 1'b0;
                  busy_reg    <= 1'b1;
                  sclk_reg    <= 1'b0;
                  bit_cnt_reg <= '0;
                  phase_reg   <= '0;
               end
            end

            S_SHIFT: begin
               if (phase_reg == PH_LAST) begin
                  phase_reg <= '0;
                  if (!sclk_reg) begin
                     sclk_reg <= 1'b1;
                  end else begin
                     // End of a high phase: falling edge, then next bit (or trailer).
                     sclk_reg <= 1'b0;
                     if (bit_cnt_reg == BIT_LAST) begin
                        state_reg <= S_TRAIL;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        mosi_reg    <= shift_reg[N-2];
                        shift_reg   <= {shift_reg[N-2:0], 1'b0};
                     end
                  end
               end else begin
                  phase_reg <= phase_reg + 1'b1;
               end
            end

            S_TRAIL: begin
               // mosi keeps the last bit here so the receiver sees a clean tail.
               if (phase_reg == PH_LAST) begin
                  phase_reg   <= '0;
                  state_reg   <= S_GAP;
                  ss_n_reg    <= 1'b1;
                  mosi_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  bit_cnt_reg <= '0;
                  shift_reg   <= '0;
               end else begin
                  phase_reg <= phase_reg + 1'b1;
               end
            end

            S_GAP: begin
               if (phase_reg == PH_LAST) begin
                  phase_reg <= '0;
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  phase_reg <= phase_reg + 1'b1;
               end
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign o_sclk = sclk_reg;
   assign o_mosi = mosi_reg;
   assign o_ss_n = ss_n_reg;
   assign o_busy = busy_reg;
   assign o_done = done_reg;

endmodule

// File: tb/tb_pov_spi_tx.sv
// Testbench for pov_spi_tx: directed frames checked bit-for-bit by an SPI
// receiver that samples o_mosi on each o_sclk rising edge, plus frame timing,
// input-change isolation, start-while-busy, async reset abort and (when
// POV_TX_AUTO_EN is defined) vsync-triggered frames.
module tb_pov_spi_tx;

   localparam int PB = 15;
   localparam int DB = 11;
   localparam int N  = 2 * PB + 4 * DB;
`ifdef POV_TX_AUTO_EN
   localparam int D  = 1;
`else
   localparam int D  = 2;
`endif
   localparam int DONE_REL = 2 * D * N + D + 1;
   localparam int BUSY_REL = 2 * D * N + 2 * D + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_start = 1'b0;
   logic [PB-1:0] i_playerX = '0;
   logic [PB-1:0] i_playerY = '0;
   logic [DB-1:0] i_facingX = '0;
   logic [DB-1:0] i_facingY = '0;
   logic [DB-1:0] i_vplaneX = '0;
   logic [DB-1:0] i_vplaneY = '0;
   logic          i_vsync = 1'b0;
   logic          o_sclk, o_mosi, o_ss_n, o_busy, o_done;

   int total = 0;
   int bad = 0;

   logic [N-1:0] rx_sr = '0;
   int           rx_cnt = 0;
   int           done_cnt = 0;

   pov_spi_tx #(.POS_BITS(PB), .DIR_BITS(DB), .CLK_DIV(D)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_start   (i_start),
      .i_playerX (i_playerX),
      .i_playerY (i_playerY),
      .i_facingX (i_facingX),
      .i_facingY (i_facingY),
      .i_vplaneX (i_vplaneX),
      .i_vplaneY (i_vplaneY),
      .i_vsync   (i_vsync),
      .o_sclk    (o_sclk),
      .o_mosi    (o_mosi),
      .o_ss_n    (o_ss_n),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   always #5 clk = ~clk;

   // Bench SPI receiver (mode 0: sample on rising SCLK).
   always @(posedge o_sclk) begin
      rx_sr  = {rx_sr[N-2:0], o_mosi};
      rx_cnt = rx_cnt + 1;
   end

   always @(negedge clk) begin
      if (o_done) done_cnt = done_cnt + 1;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic drive(input logic [N-1:0] fr);
      {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY} = fr;
   endtask

   task automatic run_frame(input string tag, input logic [N-1:0] fr,
                            input bit mid_change, input bit busy_pulse, input bit do_reset);
      int done_rel, busy_rel, rx0, d0;
      rx0 = rx_cnt;
      d0 = done_cnt;
      done_rel = -1;
      busy_rel = -1;
      @(negedge clk);
      drive(fr);
      i_start = 1'b1;
      for (int rel = 1; rel <= 1000 && busy_rel < 0; rel++) begin
         @(negedge clk);
         if (rel == 1) begin
            i_start = 1'b0;
            check({tag, "_busy1"}, 128'(o_busy), 128'd1);
            check({tag, "_ssn1"}, 128'(o_ss_n), 128'd0);
            check({tag, "_sclk1"}, 128'(o_sclk), 128'd0);
            check({tag, "_mosi1"}, 128'(o_mosi), 128'(fr[N-1]));
         end
         if (mid_change && rel == 50) drive(~fr);
         if (busy_pulse && rel == 100) i_start = 1'b1;
         if (busy_pulse && rel == 101) i_start = 1'b0;
         if (do_reset && rel == 120) begin
            reset_n = 1'b0;
            #1;
            check({tag, "_rst_ssn"}, 128'(o_ss_n), 128'd1);
            check({tag, "_rst_sclk"}, 128'(o_sclk), 128'd0);
            check({tag, "_rst_busy"}, 128'(o_busy), 128'd0);
            repeat (3) @(negedge clk);
            reset_n = 1'b1;
            repeat (5) @(negedge clk);
            check({tag, "_rst_nodone"}, 128'(done_cnt - d0), 128'd0);
            return;
         end
         if (o_done && done_rel < 0) done_rel = rel;
         if (!o_busy && busy_rel < 0) busy_rel = rel;
      end
      check({tag, "_done_cyc"}, 128'(done_rel), 128'(DONE_REL));
      check({tag, "_busy_fall"}, 128'(busy_rel), 128'(BUSY_REL));
      repeat (busy_pulse ? 400 : 10) @(negedge clk);
      check({tag, "_ndone"}, 128'(done_cnt - d0), 128'd1);
      check({tag, "_nbits"}, 128'(rx_cnt - rx0), 128'(N));
      check({tag, "_frame"}, 128'(rx_sr), 128'(fr));
   endtask

`ifdef POV_TX_AUTO_EN
   task automatic vsync_frame(input string tag, input logic [N-1:0] fr, input bit third);
      int done_rel, rx0, d0;
      rx0 = rx_cnt;
      d0 = done_cnt;
      done_rel = -1;
      @(negedge clk);
      drive(fr);
      i_vsync = 1'b1;
      for (int rel = 1; rel <= 400; rel++) begin
         @(negedge clk);
         if (rel == 5) i_vsync = 1'b0;
         if (third && rel == 60) i_vsync = 1'b1;
         if (third && rel == 65) i_vsync = 1'b0;
         if (o_done && done_rel < 0) done_rel = rel;
      end
      // One extra cycle for the registered edge detect.
      check({tag, "_done_cyc"}, 128'(done_rel), 128'(DONE_REL + 1));
      check({tag, "_ndone"}, 128'(done_cnt - d0), 128'd1);
      check({tag, "_nbits"}, 128'(rx_cnt - rx0), 128'(N));
      check({tag, "_frame"}, 128'(rx_sr), 128'(fr));
   endtask
`endif

   initial begin
      logic [N-1:0] f1, f2, f3, f4;
      f1 = {15'h4A5C, 15'h0001, 11'h400, 11'h000, 11'h000, 11'h1A3};
      f2 = {15'h1234, 15'h7FFF, 11'h7FF, 11'h001, 11'h555, 11'h2AA};
      f3 = {15'h0000, 15'h4000, 11'h3C3, 11'h0F0, 11'h00F, 11'h700};
      f4 = {15'h6B6B, 15'h1111, 11'h222, 11'h333, 11'h444, 11'h5A5};

      for (int c = 0; c < 23; c++) begin
         @(negedge clk);
         if (c == 3) reset_n = 1'b1;
         check($sformatf("idle_%0d", c), 128'({o_ss_n, o_sclk, o_mosi, o_busy, o_done}), 128'(5'b10000));
      end

      run_frame("pattern", f1, 1'b0, 1'b0, 1'b0);
      run_frame("midchg", f2, 1'b1, 1'b0, 1'b0);
      run_frame("busystart", f3, 1'b0, 1'b1, 1'b0);
      run_frame("abort", f2, 1'b0, 1'b0, 1'b1);
      run_frame("after_rst", f4, 1'b0, 1'b0, 1'b0);
`ifdef POV_TX_AUTO_EN
      vsync_frame("vsync1", f1, 1'b0);
      vsync_frame("vsync2", f3, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
